// File: rtl/mul_pkg.sv
// mul_pkg: shared widths and helpers for the shared high-half multiplier arbiter
package mul_pkg;
  localparam int MUL_W = 8;
  localparam int MUL_NREQ = 4;
  localparam int MUL_IDW = 3;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/mul_share_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from ptr with wrap
module rr_arbiter import mul_pkg::*; #(
  parameter int N = 4,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_id,
  output logic          any
);
  logic [N-1:0] rot;
  logic [PW-1:0] off;
  logic [PW:0] sum;
  // rot[k] is req[(ptr+k) mod N], so the lowest set bit is the winner's offset from ptr
  assign rot = N'({req, req} >> ptr);
  assign any = |req;
  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) if (rot[k]) off = PW'(k);
    sum = {1'b0, ptr} + {1'b0, off};
    gnt_id = (sum >= (PW + 1)'(N)) ? PW'(sum - (PW + 1)'(N)) : sum[PW-1:0];
    gnt = any ? (N'(1) << gnt_id) : '0;
  end
endmodule

// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin share of one W x W high-half multiplier over a 2-stage stallable pipe
module mul_share_arb import mul_pkg::*; #(
  parameter int W = MUL_W,
  parameter int NREQ = MUL_NREQ,
  parameter int IDW = MUL_IDW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*W-1:0] req_op1,
  input  logic [NREQ*W-1:0] req_op2,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IDW-1:0]  rsp_id,
  output logic [W-1:0]    rsp_data,
  output logic            busy
);
  localparam int PW = clog2(NREQ);
  logic [PW-1:0] rr_ptr, gnt_id;
  logic [NREQ-1:0] gnt;
  logic any, adv1, adv2, s1_valid, s2_valid;
  logic [W-1:0] s1_op1, s1_op2, sel_op1, sel_op2, s2_data, prod_hi;
  logic [IDW-1:0] s1_id, s2_id;
  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(gnt),
    .gnt_id(gnt_id),
    .any(any)
  );
  assign adv2 = ~s2_valid | rsp_ready;
  assign adv1 = ~s1_valid | adv2;
  // Ready stays low while in reset so no requester believes a dropped transfer happened
  assign req_ready = (rst & adv1) ? gnt : '0;
  assign prod_hi = W'(({{W{1'b0}}, s1_op1} * {{W{1'b0}}, s1_op2}) >> W);
  assign rsp_valid = s2_valid;
  assign rsp_id = s2_id;
  assign rsp_data = s2_data;
  assign busy = s1_valid | s2_valid;
  always_comb begin
    sel_op1 = '0;
    sel_op2 = '0;
    for (int i = 0; i < NREQ; i++) if (gnt[i]) begin
      sel_op1 = req_op1[i*W +: W];
      sel_op2 = req_op2[i*W +: W];
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_op1 <= '0;
      s1_op2 <= '0;
      s1_id <= '0;
      s2_valid <= 1'b0;
      s2_data <= '0;
      s2_id <= '0;
      rr_ptr <= '0;
    end else begin
      if (adv2) begin
        s2_valid <= s1_valid;
        s2_data <= prod_hi;
        s2_id <= s1_id;
      end
      if (adv1) begin
        s1_valid <= any;
        if (any) begin
          s1_op1 <= sel_op1;
          s1_op2 <= sel_op2;
          s1_id <= IDW'(gnt_id);
          rr_ptr <= (gnt_id == PW'(NREQ - 1)) ? '0 : gnt_id + PW'(1);
        end
      end
    end
endmodule
